// File: rtl/l2_refill_arbiter_pkg.sv
// Shared types and default geometry for the L2 refill arbiter.
// FSM states, owner encodings and bus widths live here so every file agrees on them.
package l2_refill_arbiter_pkg;

    localparam int ADDR_W     = 34;
    localparam int LINE_W     = 256;
    localparam int OFF_W      = 5;
    localparam int STARVE_MAX = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    typedef enum logic {
        OWNER_IC = 1'b0,
        OWNER_DC = 1'b1
    } owner_t;

    // Width needed to hold a saturating counter that reaches max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/l2_refill_arbiter_if.sv
// Bundle of the Icache, Dcache and L2 handshake buses around the refill arbiter.
// Handshakes: a transfer happens on a clk edge where valid and ready are both 1;
// the source holds valid and all payload stable until that edge, l2_resp_valid is a one-cycle pulse.
interface l2_refill_arbiter_if #(
    parameter int ADDR_W = l2_refill_arbiter_pkg::ADDR_W,
    parameter int LINE_W = l2_refill_arbiter_pkg::LINE_W
);

    logic              ic_req_valid;
    logic              ic_req_ready;
    logic [ADDR_W-1:0] ic_req_addr;
    logic              ic_resp_valid;
    logic              ic_resp_ready;
    logic [LINE_W-1:0] ic_resp_line;

    logic              dc_req_valid;
    logic              dc_req_ready;
    logic [ADDR_W-1:0] dc_req_addr;
    logic              dc_req_we;
    logic [LINE_W-1:0] dc_req_wdata;
    logic              dc_resp_valid;
    logic              dc_resp_ready;
    logic [LINE_W-1:0] dc_resp_line;

    logic              l2_req_valid;
    logic              l2_req_ready;
    logic [ADDR_W-1:0] l2_req_addr;
    logic              l2_req_we;
    logic [LINE_W-1:0] l2_req_wdata;
    logic              l2_resp_valid;
    logic [LINE_W-1:0] l2_resp_line;

    // Arbiter side.
    modport slave (
        input  ic_req_valid, ic_req_addr, ic_resp_ready,
        output ic_req_ready, ic_resp_valid, ic_resp_line,
        input  dc_req_valid, dc_req_addr, dc_req_we, dc_req_wdata, dc_resp_ready,
        output dc_req_ready, dc_resp_valid, dc_resp_line,
        output l2_req_valid, l2_req_addr, l2_req_we, l2_req_wdata,
        input  l2_req_ready, l2_resp_valid, l2_resp_line
    );

    // Environment side: caches plus the L2.
    modport master (
        output ic_req_valid, ic_req_addr, ic_resp_ready,
        input  ic_req_ready, ic_resp_valid, ic_resp_line,
        output dc_req_valid, dc_req_addr, dc_req_we, dc_req_wdata, dc_resp_ready,
        input  dc_req_ready, dc_resp_valid, dc_resp_line,
        input  l2_req_valid, l2_req_addr, l2_req_we, l2_req_wdata,
        output l2_req_ready, l2_resp_valid, l2_resp_line
    );

endinterface

// File: rtl/l2_refill_arbiter_pick.sv
// Icache-first priority pick with a saturating starvation counter that forces a Dcache grant.
// Grants are only raised while the arbiter is idle, so a grant is also an accept.
module l2_arb_pick
    import l2_refill_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = l2_refill_arbiter_pkg::STARVE_MAX,
    parameter int CNT_W      = cnt_width(STARVE_MAX)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             idle,
    input  logic             ic_valid,
    input  logic             dc_valid,
    output logic             grant_ic,
    output logic             grant_dc,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] cnt_q;
    logic             starved;

    assign starved = (cnt_q == CNT_MAX);

    always_comb begin
        grant_dc = 1'b0;
        grant_ic = 1'b0;
        if (idle) begin
            grant_dc = dc_valid && (starved || !ic_valid);
            grant_ic = ic_valid && !grant_dc;
        end
    end

    // Counts Icache wins only while the Dcache is actually waiting.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (!dc_valid || grant_dc) begin
            cnt_q <= '0;
        end else if (grant_ic && !starved) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/l2_refill_arbiter.sv
// Shares the single L2 refill port between the Icache miss path and the Dcache miss/writeback path.
// One line transaction at a time: IDLE accept -> REQ to L2 -> WAIT for data -> RESP to the owner.
module l2_refill_arbiter
    import l2_refill_arbiter_pkg::*;
#(
    parameter int ADDR_W     = l2_refill_arbiter_pkg::ADDR_W,
    parameter int LINE_W     = l2_refill_arbiter_pkg::LINE_W,
    parameter int OFF_W      = l2_refill_arbiter_pkg::OFF_W,
    parameter int STARVE_MAX = l2_refill_arbiter_pkg::STARVE_MAX,
    parameter int CNT_W      = cnt_width(STARVE_MAX)
) (
    input  logic                  clk,
    input  logic                  rst,
    l2_refill_arbiter_if.slave    bus,
    output logic                  busy,
    output logic                  owner,
    output logic                  proto_err,
    output state_t                fsm_state,
    output logic [CNT_W-1:0]      starve_cnt
);

    state_t            state_q;
    state_t            state_d;

    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [LINE_W-1:0] wdata_q;
    logic              owner_q;
    logic [LINE_W-1:0] line_q;
    logic              proto_err_q;

    logic              grant_ic;
    logic              grant_dc;
    logic              accept;
    logic              resp_ready;

    l2_arb_pick #(
        .STARVE_MAX (STARVE_MAX),
        .CNT_W      (CNT_W)
    ) u_pick (
        .clk      (clk),
        .rst      (rst),
        .idle     (state_q == IDLE),
        .ic_valid (bus.ic_req_valid),
        .dc_valid (bus.dc_req_valid),
        .grant_ic (grant_ic),
        .grant_dc (grant_dc),
        .cnt      (starve_cnt)
    );

    // A grant implies the winner is valid, so grant alone marks the accept edge.
    assign accept     = (grant_ic || grant_dc) && !rst;
    assign resp_ready = (owner_q == OWNER_DC) ? bus.dc_resp_ready : bus.ic_resp_ready;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept)            state_d = REQ;
            REQ:  if (bus.l2_req_ready)  state_d = WAIT;
            WAIT: if (bus.l2_resp_valid) state_d = RESP;
            RESP: if (resp_ready)        state_d = IDLE;
            default:                     state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            owner_q     <= OWNER_IC;
            line_q      <= '0;
            proto_err_q <= 1'b0;
        end else begin
            if (state_q == IDLE && accept) begin
                if (grant_dc) begin
                    addr_q  <= {bus.dc_req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    we_q    <= bus.dc_req_we;
                    wdata_q <= bus.dc_req_wdata;
                    owner_q <= OWNER_DC;
                end else begin
                    addr_q  <= {bus.ic_req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    we_q    <= 1'b0;
                    wdata_q <= '0;
                    owner_q <= OWNER_IC;
                end
            end
            if (state_q == WAIT && bus.l2_resp_valid) begin
                line_q <= bus.l2_resp_line;
            end
            // A response outside WAIT has no transaction to belong to; it is dropped and flagged.
            if (state_q != WAIT && bus.l2_resp_valid) begin
                proto_err_q <= 1'b1;
            end
        end
    end

    assign bus.ic_req_ready  = grant_ic && !rst;
    assign bus.dc_req_ready  = grant_dc && !rst;

    assign bus.l2_req_valid  = (state_q == REQ);
    assign bus.l2_req_addr   = addr_q;
    assign bus.l2_req_we     = we_q;
    assign bus.l2_req_wdata  = wdata_q;

    assign bus.ic_resp_valid = (state_q == RESP) && (owner_q == OWNER_IC);
    assign bus.dc_resp_valid = (state_q == RESP) && (owner_q == OWNER_DC);
    assign bus.ic_resp_line  = line_q;
    assign bus.dc_resp_line  = line_q;

    assign busy      = (state_q != IDLE);
    assign owner     = owner_q;
    assign proto_err = proto_err_q;
    assign fsm_state = state_q;

    a_one_grant: assert property (@(posedge clk) disable iff (rst) !(grant_ic && grant_dc));

    a_l2_req_hold: assert property (@(posedge clk) disable iff (rst)
        (bus.l2_req_valid && !bus.l2_req_ready) |=>
        (bus.l2_req_valid && $stable(bus.l2_req_addr) && $stable(bus.l2_req_we) && $stable(bus.l2_req_wdata)));

endmodule

// File: tb/tb_l2_refill_arbiter.sv
// Directed bench for l2_refill_arbiter: reset, single Icache refill, starvation order,
// delayed writeback, response back-pressure, stray L2 responses and reset mid-transaction.
module tb_l2_refill_arbiter;
    import l2_refill_arbiter_pkg::*;

    localparam int CNT_W = cnt_width(STARVE_MAX);

    logic             clk;
    logic             rst;
    logic             busy;
    logic             owner;
    logic             proto_err;
    state_t           fsm_state;
    logic [CNT_W-1:0] starve_cnt;

    int n_tests;
    int n_fail;

    logic [LINE_W-1:0] exp_q[$];
    logic [LINE_W-1:0] exp_line;
    logic [LINE_W-1:0] line_a5;
    logic [LINE_W-1:0] line_5a;
    logic [LINE_W-1:0] line_3c;
    logic [LINE_W-1:0] wdata_dead;

    l2_refill_arbiter_if bus ();

    l2_refill_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .busy       (busy),
        .owner      (owner),
        .proto_err  (proto_err),
        .fsm_state  (fsm_state),
        .starve_cnt (starve_cnt)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.ic_req_valid  = 1'b0;
        bus.ic_req_addr   = '0;
        bus.ic_resp_ready = 1'b0;
        bus.dc_req_valid  = 1'b0;
        bus.dc_req_addr   = '0;
        bus.dc_req_we     = 1'b0;
        bus.dc_req_wdata  = '0;
        bus.dc_resp_ready = 1'b0;
        bus.l2_req_ready  = 1'b0;
        bus.l2_resp_valid = 1'b0;
        bus.l2_resp_line  = '0;
    endtask

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] l;
        for (int w = 0; w < LINE_W / 32; w++) l[w*32 +: 32] = $urandom_range(32'hFFFF_FFFF, 0);
        return l;
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        bus.ic_req_valid = 1'b1;
        bus.dc_req_valid = 1'b1;
        tick();
        tick();
        @(negedge clk);
        n_tests++; if (bus.ic_req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ic_ready: got %b want 0", bus.ic_req_ready); end
        n_tests++; if (bus.dc_req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_dc_ready: got %b want 0", bus.dc_req_ready); end
        n_tests++; if (bus.l2_req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_l2_valid: got %b want 0", bus.l2_req_valid); end
        n_tests++; if (busy !== 1'b0 || owner !== 1'b0 || proto_err !== 1'b0) begin n_fail++; $display("FAIL rst_status: busy/owner/err got %b%b%b want 000", busy, owner, proto_err); end
        n_tests++; if (starve_cnt !== '0) begin n_fail++; $display("FAIL rst_cnt: got %0d want 0", starve_cnt); end
        n_tests++; if (bus.l2_req_addr !== '0 || bus.ic_resp_line !== '0) begin n_fail++; $display("FAIL rst_regs: addr %h line %h want 0", bus.l2_req_addr, bus.ic_resp_line); end
        tick();
        rst = 1'b0;
        bus.ic_req_valid = 1'b0;
        bus.dc_req_valid = 1'b0;
        tick();
    endtask

    task automatic test_icache_only();
        bus.ic_req_valid = 1'b1;
        bus.ic_req_addr  = 34'h2_0000_1234;
        bus.l2_req_ready = 1'b1;
        @(negedge clk);
        n_tests++; if (bus.ic_req_ready !== 1'b1) begin n_fail++; $display("FAIL ic_ready: got %b want 1", bus.ic_req_ready); end
        n_tests++; if (bus.dc_req_ready !== 1'b0) begin n_fail++; $display("FAIL ic_only_dc_ready: got %b want 0", bus.dc_req_ready); end
        tick();  // accept (T)
        bus.ic_req_valid = 1'b0;
        @(negedge clk);
        n_tests++; if (bus.l2_req_valid !== 1'b1) begin n_fail++; $display("FAIL ic_l2_valid: got %b want 1", bus.l2_req_valid); end
        n_tests++; if (bus.l2_req_addr !== 34'h2_0000_1220) begin n_fail++; $display("FAIL ic_l2_addr: got %h want 200001220", bus.l2_req_addr); end
        n_tests++; if (bus.l2_req_we !== 1'b0 || bus.l2_req_wdata !== '0) begin n_fail++; $display("FAIL ic_l2_we: we %b wdata %h want 0", bus.l2_req_we, bus.l2_req_wdata); end
        n_tests++; if (owner !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL ic_owner_busy: got %b%b want 01", owner, busy); end
        tick();  // T+1: L2 accepts
        bus.l2_req_ready  = 1'b0;
        bus.l2_resp_valid = 1'b1;
        bus.l2_resp_line  = line_a5;
        @(negedge clk);
        n_tests++; if (fsm_state !== WAIT) begin n_fail++; $display("FAIL ic_state_wait: got %0d want %0d", fsm_state, WAIT); end
        n_tests++; if (bus.ic_resp_valid !== 1'b0) begin n_fail++; $display("FAIL ic_resp_early: got %b want 0", bus.ic_resp_valid); end
        tick();  // T+2: response captured
        bus.l2_resp_valid = 1'b0;
        bus.l2_resp_line  = '0;
        @(negedge clk);
        n_tests++; if (bus.ic_resp_valid !== 1'b1) begin n_fail++; $display("FAIL ic_resp_valid: got %b want 1", bus.ic_resp_valid); end
        n_tests++; if (bus.ic_resp_line !== line_a5) begin n_fail++; $display("FAIL ic_resp_line: got %h want %h", bus.ic_resp_line, line_a5); end
        n_tests++; if (bus.dc_resp_valid !== 1'b0) begin n_fail++; $display("FAIL ic_dc_resp: got %b want 0", bus.dc_resp_valid); end
        bus.ic_resp_ready = 1'b1;
        tick();
        bus.ic_resp_ready = 1'b0;
        @(negedge clk);
        n_tests++; if (busy !== 1'b0 || bus.ic_resp_valid !== 1'b0) begin n_fail++; $display("FAIL ic_done: busy %b resp %b want 00", busy, bus.ic_resp_valid); end
        tick();
    endtask

    task automatic test_starvation();
        logic              exp_dc;
        logic [CNT_W-1:0]  exp_cnt;
        logic [ADDR_W-1:0] exp_addr;
        logic [LINE_W-1:0] l2_line;
        bus.ic_req_valid  = 1'b1;
        bus.ic_req_addr   = 34'h0_0000_101F;
        bus.dc_req_valid  = 1'b1;
        bus.dc_req_addr   = 34'h3_FFFF_FFFF;
        bus.dc_req_we     = 1'b0;
        bus.l2_req_ready  = 1'b1;
        bus.ic_resp_ready = 1'b1;
        bus.dc_resp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            exp_dc   = (k == 3);
            exp_cnt  = (k == 0) ? 1 : (k == 1) ? 2 : (k == 2) ? 3 : (k == 3) ? 0 : 1;
            exp_addr = exp_dc ? 34'h3_FFFF_FFE0 : 34'h0_0000_1000;
            @(negedge clk);
            n_tests++; if (bus.dc_req_ready !== exp_dc || bus.ic_req_ready !== !exp_dc) begin n_fail++; $display("FAIL starve_grant_%0d: ic/dc ready %b%b want %b%b", k, bus.ic_req_ready, bus.dc_req_ready, !exp_dc, exp_dc); end
            tick();  // accept
            @(negedge clk);
            n_tests++; if (owner !== exp_dc) begin n_fail++; $display("FAIL starve_owner_%0d: got %b want %b", k, owner, exp_dc); end
            n_tests++; if (starve_cnt !== exp_cnt) begin n_fail++; $display("FAIL starve_cnt_%0d: got %0d want %0d", k, starve_cnt, exp_cnt); end
            n_tests++; if (bus.l2_req_addr !== exp_addr) begin n_fail++; $display("FAIL starve_addr_%0d: got %h want %h", k, bus.l2_req_addr, exp_addr); end
            tick();  // L2 takes request
            l2_line = rand_line();
            exp_q.push_back(l2_line);
            bus.l2_resp_valid = 1'b1;
            bus.l2_resp_line  = l2_line;
            tick();
            bus.l2_resp_valid = 1'b0;
            @(negedge clk);
            exp_line = exp_q.pop_front();
            n_tests++; if ((exp_dc ? bus.dc_resp_valid : bus.ic_resp_valid) !== 1'b1) begin n_fail++; $display("FAIL starve_resp_%0d: ic/dc valid %b%b", k, bus.ic_resp_valid, bus.dc_resp_valid); end
            n_tests++; if ((exp_dc ? bus.dc_resp_line : bus.ic_resp_line) !== exp_line) begin n_fail++; $display("FAIL starve_line_%0d: got %h want %h", k, exp_dc ? bus.dc_resp_line : bus.ic_resp_line, exp_line); end
            tick();  // response consumed, back to IDLE
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_writeback();
        bus.dc_req_valid = 1'b1;
        bus.dc_req_addr  = 34'h1_2345_678F;
        bus.dc_req_we    = 1'b1;
        bus.dc_req_wdata = wdata_dead;
        @(negedge clk);
        n_tests++; if (bus.dc_req_ready !== 1'b1) begin n_fail++; $display("FAIL wb_dc_ready: got %b want 1", bus.dc_req_ready); end
        tick();  // accept
        bus.dc_req_valid = 1'b0;
        bus.dc_req_wdata = '0;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) bus.l2_req_ready = 1'b1;
            @(negedge clk);
            n_tests++; if (bus.l2_req_valid !== 1'b1 || bus.l2_req_we !== 1'b1) begin n_fail++; $display("FAIL wb_l2_hold_%0d: valid %b we %b want 11", i, bus.l2_req_valid, bus.l2_req_we); end
            n_tests++; if (bus.l2_req_addr !== 34'h1_2345_6780 || bus.l2_req_wdata !== wdata_dead) begin n_fail++; $display("FAIL wb_l2_fields_%0d: addr %h wdata %h", i, bus.l2_req_addr, bus.l2_req_wdata); end
            tick();
        end
        bus.l2_req_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_tests++; if (bus.dc_resp_valid !== 1'b0 || bus.l2_req_valid !== 1'b0) begin n_fail++; $display("FAIL wb_wait_%0d: dc_resp %b l2_valid %b want 00", i, bus.dc_resp_valid, bus.l2_req_valid); end
            tick();
        end
        bus.l2_resp_valid = 1'b1;
        bus.l2_resp_line  = line_5a;
        tick();
        bus.l2_resp_valid = 1'b0;
        bus.l2_resp_line  = '0;
        @(negedge clk);
        n_tests++; if (bus.dc_resp_valid !== 1'b1 || bus.ic_resp_valid !== 1'b0) begin n_fail++; $display("FAIL wb_resp: ic/dc valid %b%b want 01", bus.ic_resp_valid, bus.dc_resp_valid); end
        n_tests++; if (bus.dc_resp_line !== line_5a || owner !== 1'b1) begin n_fail++; $display("FAIL wb_line: line %h owner %b", bus.dc_resp_line, owner); end
        bus.dc_resp_ready = 1'b1;
        tick();
        bus.dc_resp_ready = 1'b0;
        @(negedge clk);
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wb_done: busy %b want 0", busy); end
        idle_inputs();
        tick();
    endtask

    task automatic test_back_pressure();
        bus.ic_req_valid = 1'b1;
        bus.ic_req_addr  = 34'h0_0000_0040;
        bus.l2_req_ready = 1'b1;
        tick();  // accept
        bus.ic_req_valid = 1'b0;
        tick();  // REQ -> WAIT
        bus.l2_req_ready  = 1'b0;
        bus.l2_resp_valid = 1'b1;
        bus.l2_resp_line  = line_3c;
        tick();
        bus.l2_resp_valid = 1'b0;
        bus.l2_resp_line  = '0;
        bus.ic_req_valid  = 1'b1;
        bus.ic_req_addr   = 34'h0_0000_0080;
        bus.dc_req_valid  = 1'b1;
        bus.dc_req_addr   = 34'h0_0000_00C0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_tests++; if (bus.ic_resp_valid !== 1'b1 || bus.ic_resp_line !== line_3c) begin n_fail++; $display("FAIL bp_hold_%0d: valid %b line %h", i, bus.ic_resp_valid, bus.ic_resp_line); end
            n_tests++; if (bus.ic_req_ready !== 1'b0 || bus.dc_req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_%0d: ic/dc ready %b%b want 00", i, bus.ic_req_ready, bus.dc_req_ready); end
            tick();
        end
        bus.ic_resp_ready = 1'b1;
        @(negedge clk);
        n_tests++; if (bus.ic_req_ready !== 1'b0 || bus.dc_req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_same_cycle: ic/dc ready %b%b want 00", bus.ic_req_ready, bus.dc_req_ready); end
        tick();  // RESP -> IDLE
        bus.ic_resp_ready = 1'b0;
        @(negedge clk);
        n_tests++; if (busy !== 1'b0 || bus.ic_req_ready !== 1'b1 || bus.dc_req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_next_idle: busy %b ic/dc ready %b%b want 0 10", busy, bus.ic_req_ready, bus.dc_req_ready); end
        idle_inputs();
        tick();
    endtask

    task automatic test_stray_resp();
        bus.l2_resp_valid = 1'b1;
        bus.l2_resp_line  = line_a5;
        tick();
        bus.l2_resp_valid = 1'b0;
        bus.l2_resp_line  = '0;
        @(negedge clk);
        n_tests++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL stray_err: got %b want 1", proto_err); end
        n_tests++; if (fsm_state !== IDLE || busy !== 1'b0) begin n_fail++; $display("FAIL stray_state: state %0d busy %b want IDLE 0", fsm_state, busy); end
        n_tests++; if (bus.ic_resp_valid !== 1'b0 || bus.dc_resp_valid !== 1'b0) begin n_fail++; $display("FAIL stray_resp: ic/dc %b%b want 00", bus.ic_resp_valid, bus.dc_resp_valid); end
        tick();
        tick();
        tick();
        @(negedge clk);
        n_tests++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL stray_sticky: got %b want 1", proto_err); end
        tick();
    endtask

    task automatic test_reset_in_wait();
        bus.ic_req_valid = 1'b1;
        bus.ic_req_addr  = 34'h0_0000_2000;
        bus.dc_req_valid = 1'b1;
        bus.dc_req_addr  = 34'h0_0000_3000;
        bus.l2_req_ready = 1'b1;
        @(negedge clk);
        n_tests++; if (bus.ic_req_ready !== 1'b1) begin n_fail++; $display("FAIL rw_ic_wins: got %b want 1", bus.ic_req_ready); end
        tick();  // accept Icache with Dcache waiting
        bus.ic_req_valid = 1'b0;
        tick();  // REQ -> WAIT
        bus.l2_req_ready = 1'b0;
        @(negedge clk);
        n_tests++; if (fsm_state !== WAIT || starve_cnt !== 1) begin n_fail++; $display("FAIL rw_pre: state %0d cnt %0d want %0d 1", fsm_state, starve_cnt, WAIT); end
        rst = 1'b1;
        bus.dc_req_valid = 1'b0;
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_tests++; if (busy !== 1'b0 || fsm_state !== IDLE || owner !== 1'b0) begin n_fail++; $display("FAIL rw_state: busy %b state %0d owner %b", busy, fsm_state, owner); end
        n_tests++; if (bus.l2_req_valid !== 1'b0 || bus.ic_resp_valid !== 1'b0 || bus.dc_resp_valid !== 1'b0) begin n_fail++; $display("FAIL rw_valids: l2/ic/dc %b%b%b want 000", bus.l2_req_valid, bus.ic_resp_valid, bus.dc_resp_valid); end
        n_tests++; if (starve_cnt !== '0 || proto_err !== 1'b0) begin n_fail++; $display("FAIL rw_cnt_err: cnt %0d err %b want 0 0", starve_cnt, proto_err); end
        bus.l2_resp_valid = 1'b1;
        bus.l2_resp_line  = line_5a;
        tick();
        bus.l2_resp_valid = 1'b0;
        bus.l2_resp_line  = '0;
        @(negedge clk);
        n_tests++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL rw_late_err: got %b want 1", proto_err); end
        n_tests++; if (bus.ic_resp_valid !== 1'b0 || bus.dc_resp_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rw_late_resp: ic/dc %b%b busy %b", bus.ic_resp_valid, bus.dc_resp_valid, busy); end
        tick();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        n_tests    = 0;
        n_fail     = 0;
        line_a5    = {32{8'hA5}};
        line_5a    = {32{8'h5A}};
        line_3c    = {32{8'h3C}};
        wdata_dead = {8{32'hDEAD_BEEF}};
        rst        = 1'b1;
        idle_inputs();

        test_reset();
        test_icache_only();
        test_starvation();
        test_writeback();
        test_back_pressure();
        test_stray_resp();
        test_reset_in_wait();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
